mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Sequencing controller for the MAC datapath: on a start pulse it walks every output element C[i][j] of an M×K by K×N matrix product, reading A and B from their memories and forming the K products through a two-stage multiply/accumulate pipeline. It writes each finished dot product to the C memory with a ready/valid stall. It sits between the matrix memories and the host control logic, replacing hand-driven `do_mac` stepping.

## Interface
- `M`, 4, rows of A / C
- `N`, 4, columns of B / C
- `K`, 4, inner dimension (columns of A, rows of B)
- `DATA_WIDTH_INIT_MATRIX`, 32, A/B element width (unsigned)
- `DATA_WIDTH_RESULT_MATRIX`, 2*DATA_WIDTH_INIT_MATRIX+$clog2(K), C element / accumulator width
- `clk`  in  1  sole clock, rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `start`  in  1  begin a full matrix product (sampled only in IDLE)
- `stop`  in  1  abort the current product
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse after the last C write is accepted
- `row_addr_a`  out  $clog2(M)  A row address
- `col_addr_a`  out  $clog2(K)  A column address
- `matrix_a_re`  out  1  A read enable
- `row_addr_b`  out  $clog2(K)  B row address
- `col_addr_b`  out  $clog2(N)  B column address
- `matrix_b_re`  out  1  B read enable
- `data_in_a`, `data_in_b`  in  DATA_WIDTH_INIT_MATRIX each  read data, valid the cycle after the enable
- `c_row_addr`  out  $clog2(M)  C write row
- `c_col_addr`  out  $clog2(N)  C write column
- `c_data`  out  DATA_WIDTH_RESULT_MATRIX  C write data
- `c_we`  out  1  C write valid
- `c_ready`  in  1  C memory accepts the write when `c_we && c_ready`

## Operation
- FSM states:
  - IDLE: `start && !stop` → READ (i=j=k=0).
  - READ: K cycles; `matrix_a_re`=`matrix_b_re`=1 with A[i][k] and B[k][j]; k counts 0..K-1, then → DRAIN.
  - DRAIN: 2 cycles → WRITE.
  - WRITE: `c_we`=1 with {i, j, acc}; held with stable values until `c_ready`. On accept, j increments; at N-1, j wraps to 0 and i increments.
    - If the accept was for (M-1,N-1) → DONE; otherwise → READ.
  - DONE: `done`=1 for one cycle → IDLE.
- Pipeline, separate from the FSM:
  - Stage 1 registers `data_in_a*data_in_b` (2*DATA_WIDTH_INIT_MATRIX bits) for the cycle after each read enable.
  - Stage 2 adds the zero-extended product into `acc`. The k=0 product loads `acc` rather than adding.
- Arithmetic is unsigned. `acc` cannot overflow by construction; there is no wrap handling.
- `stop` in any non-IDLE state → IDLE next edge.
  - Counters and pipeline valids clear.
  - No `c_we` or `done` is issued.
  - `acc` contents are don't-care.
- `start` is ignored when not in IDLE. If `start` and `stop` are high in the same IDLE cycle, `stop` wins.
- Reset: state IDLE; all outputs 0 (`busy`, `done`, enables, `c_we`, addresses, `c_data`); counters 0.

## Timing
- `start` high at edge 0 → first read enable in cycle 1.
- Per element: K+3 cycles when `c_ready` is held high; each cycle `c_ready` is low adds one.
- Total: `done` high in cycle 1+M*N*(K+3) plus stall cycles. For 4/4/4 with no stall, this is cycle 113.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- `c_we` is never asserted while read enables are high.

## Configuration
- `MAC_SEQ_STALL_CNT_EN`: when defined, adds output `stall_cycles` (32 bits).
  - Counts cycles with `c_we && !c_ready`.
  - Clears on reset and on an accepted `start`.
  - Saturates at all-ones.
- When undefined: the port and the counter are absent, and the controller is otherwise identical.

## Structure
- Package `mac_seq_pkg`:
  - FSM state enum (IDLE, READ, DRAIN, WRITE, DONE).
  - Drain-depth constant (2).
  - Width helper functions for the address and result widths.
- Sub-module `mac_seq_datapath`: stage-1 product register, stage-2 accumulator and the valid/first-flag pipeline. The FSM and address counters stay in `mac_seq_ctrl`.

## Test plan
- Reset: hold `resetn`=0 for 3 cycles with `start`=1 → all outputs 0 and `busy`=0 throughout.
- Functional run: A = {6,2,5,2; 6,2,6,1; 2,4,5,2; 7,2,5,1}, B = {1,1,4,4; 1,7,2,1; 3,2,1,1; 2,1,6,6}, `c_ready`=1.
  - 16 writes in row-major order.
  - C[0][0]=27, C[0][3]=43, C[3][3]=41.
  - `done` in cycle 113.
- Width corner: all A and B elements = 32'hFFFF_FFFF → every C element = 66'h3_FFFF_FFF8_0000_0004.
- Stall: `c_ready`=0 for 5 cycles on the first write.
  - `c_we`, `c_data` and addresses are held stable, and no read enables occur.
  - `done` arrives in cycle 118.
  - With `MAC_SEQ_STALL_CNT_EN`, `stall_cycles`=5.
- Abort: `stop` in cycle 20.
  - `busy`=0 in cycle 21; no further `c_we`; no `done`.
  - A following `start` reproduces the functional-run results exactly.
- Collision: `start` and `stop` in the same IDLE cycle → stays IDLE. `start` pulsed mid-run → ignored, and the write count stays at 16.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// -----------------------------------------------------------------------------
// mac_seq_pkg
// Shared definitions for the MAC sequencing controller:
//   - state_t        : controller FSM state encoding
//   - DRAIN_DEPTH    : cycles between the last read enable and a valid result
//   - DRAIN_CNT_W    : width of the drain cycle counter
//   - addr_width()   : address width for a dimension (never less than 1 bit)
//   - result_width() : accumulator width that cannot overflow for K products
// No ports (package only).
// -----------------------------------------------------------------------------
package mac_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Memory read latency (1) plus the product register stage (1).
  localparam int DRAIN_DEPTH = 2;
  localparam int DRAIN_CNT_W = 2;

  // A dimension of 1 still needs a 1-bit address port.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Each product is 2*dw bits; summing k of them adds clog2(k) carry bits.
  function automatic int result_width(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

endpackage

// File: rtl/mac_seq_datapath.sv
// -----------------------------------------------------------------------------
// mac_seq_datapath
// Two-stage unsigned multiply/accumulate pipeline fed by the matrix memories.
//   Stage 1: registers i_a*i_b in the cycle the memory data is valid
//            (one cycle after the read enable).
//   Stage 2: loads (first product of a dot product) or adds the zero-extended
//            product into the accumulator.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   i_clear          drop all in-flight pipeline valids (abort)
//   i_rd_en          read enable issued to the A/B memories this cycle
//   i_rd_first       the read issued this cycle is element k=0
//   i_a, i_b         memory read data (valid the cycle after i_rd_en)
//   o_acc            accumulator value
// -----------------------------------------------------------------------------
module mac_seq_datapath
  import mac_seq_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 66
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_clear,
  input  logic          i_rd_en,
  input  logic          i_rd_first,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [RW-1:0] o_acc
);

  // r_v0/r_f0: memory data valid this cycle; r_v1/r_f1: product valid.
  logic            r_v0;
  logic            r_f0;
  logic            r_v1;
  logic            r_f1;
  logic [2*DW-1:0] r_prod;
  logic [RW-1:0]   r_acc;
  logic [2*DW-1:0] w_prod;

  assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_v0   <= 1'b0;
      r_f0   <= 1'b0;
      r_v1   <= 1'b0;
      r_f1   <= 1'b0;
      r_prod <= '0;
      r_acc  <= '0;
    end else if (i_clear) begin
      // Accumulator contents are left as-is; the next k=0 product reloads it.
      r_v0 <= 1'b0;
      r_f0 <= 1'b0;
      r_v1 <= 1'b0;
      r_f1 <= 1'b0;
    end else begin
      r_v0 <= i_rd_en;
      r_f0 <= i_rd_first;
      r_v1 <= r_v0;
      r_f1 <= r_f0;
      if (r_v0) begin
        r_prod <= w_prod;
      end
      if (r_v1) begin
        r_acc <= r_f1 ? RW'(r_prod) : (r_acc + RW'(r_prod));
      end
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
// Sequencer for C = A x B (A is MxK, B is KxN). On start it walks every C[i][j]
// in row-major order: K read cycles, DRAIN_DEPTH drain cycles, then one write
// to the C memory held until accepted. Element cost is K+3 cycles without
// back-pressure.
//
// Optional feature macro: MAC_SEQ_STALL_CNT_EN
//   When defined, adds output stall_cycles[31:0], counting cycles with
//   c_we && !c_ready; cleared on reset and on an accepted start; saturating.
//
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   start, stop                      begin a product (IDLE only) / abort
//   busy, done                       not-IDLE flag / one-cycle completion pulse
//   row_addr_a, col_addr_a, matrix_a_re   A memory read port
//   row_addr_b, col_addr_b, matrix_b_re   B memory read port
//   data_in_a, data_in_b             read data, valid the cycle after enable
//   c_row_addr, c_col_addr, c_data, c_we  C memory write port
//   c_ready                          C memory write acceptance
//
// C write handshake: c_we is the valid. While c_we=1 and c_ready=0 the
// controller holds c_we, c_row_addr, c_col_addr and c_data stable; the write
// transfers on a rising edge where c_we && c_ready, and c_we drops (or moves
// to the next element) only after that edge.
// -----------------------------------------------------------------------------
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int M                        = 4,
  parameter int N                        = 4,
  parameter int K                        = 4,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = result_width(DATA_WIDTH_INIT_MATRIX, K)
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                start,
  input  logic                                stop,
  output logic                                busy,
  output logic                                done,
  output logic [addr_width(M)-1:0]            row_addr_a,
  output logic [addr_width(K)-1:0]            col_addr_a,
  output logic                                matrix_a_re,
  output logic [addr_width(K)-1:0]            row_addr_b,
  output logic [addr_width(N)-1:0]            col_addr_b,
  output logic                                matrix_b_re,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_a,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_b,
  output logic [addr_width(M)-1:0]            c_row_addr,
  output logic [addr_width(N)-1:0]            c_col_addr,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] c_data,
  output logic                                c_we,
  input  logic                                c_ready
`ifdef MAC_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]                         stall_cycles
`endif
);

  localparam int MW = addr_width(M);
  localparam int NW = addr_width(N);
  localparam int KW = addr_width(K);

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_re;
  logic                   r_c_we;
  logic [MW-1:0]          r_i;
  logic [NW-1:0]          r_j;
  logic [KW-1:0]          r_k;
  logic [DRAIN_CNT_W-1:0] r_drain;
  logic [MW-1:0]          r_row_a;
  logic [KW-1:0]          r_col_a;
  logic [KW-1:0]          r_row_b;
  logic [NW-1:0]          r_col_b;
  logic [MW-1:0]          r_c_row;
  logic [NW-1:0]          r_c_col;

  logic w_abort;
  logic w_last_i;
  logic w_last_j;
  logic w_last_k;
  logic w_rd_first;

  assign w_abort    = stop && (r_state != ST_IDLE);
  assign w_last_i   = (r_i == MW'(M - 1));
  assign w_last_j   = (r_j == NW'(N - 1));
  assign w_last_k   = (r_k == KW'(K - 1));
  // r_k tracks the k of the read enable currently on the bus.
  assign w_rd_first = (r_k == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_re    <= 1'b0;
      r_c_we  <= 1'b0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_drain <= '0;
      r_row_a <= '0;
      r_col_a <= '0;
      r_row_b <= '0;
      r_col_b <= '0;
      r_c_row <= '0;
      r_c_col <= '0;
    end else if (w_abort) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_re    <= 1'b0;
      r_c_we  <= 1'b0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_drain <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !stop) begin
            r_state <= ST_READ;
            r_busy  <= 1'b1;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_re    <= 1'b1;
            r_row_a <= '0;
            r_col_a <= '0;
            r_row_b <= '0;
            r_col_b <= '0;
          end
        end

        ST_READ: begin
          if (w_last_k) begin
            r_state <= ST_DRAIN;
            r_re    <= 1'b0;
            r_drain <= '0;
          end else begin
            r_k     <= r_k + KW'(1);
            r_col_a <= r_k + KW'(1);
            r_row_b <= r_k + KW'(1);
          end
        end

        ST_DRAIN: begin
          if (r_drain == DRAIN_CNT_W'(DRAIN_DEPTH - 1)) begin
            r_state <= ST_WRITE;
            r_c_we  <= 1'b1;
            r_c_row <= r_i;
            r_c_col <= r_j;
          end else begin
            r_drain <= r_drain + DRAIN_CNT_W'(1);
          end
        end

        ST_WRITE: begin
          if (c_ready) begin
            r_c_we <= 1'b0;
            if (w_last_i && w_last_j) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_READ;
              r_re    <= 1'b1;
              r_k     <= '0;
              r_col_a <= '0;
              r_row_b <= '0;
              if (w_last_j) begin
                r_j     <= '0;
                r_i     <= r_i + MW'(1);
                r_row_a <= r_i + MW'(1);
                r_col_b <= '0;
              end else begin
                r_j     <= r_j + NW'(1);
                r_col_b <= r_j + NW'(1);
              end
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_i     <= '0;
          r_j     <= '0;
          r_k     <= '0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_re    <= 1'b0;
          r_c_we  <= 1'b0;
        end
      endcase
    end
  end

  mac_seq_datapath #(
    .DW (DATA_WIDTH_INIT_MATRIX),
    .RW (DATA_WIDTH_RESULT_MATRIX)
  ) u_datapath (
    .clk        (clk),
    .resetn     (resetn),
    .i_clear    (w_abort),
    .i_rd_en    (r_re),
    .i_rd_first (w_rd_first),
    .i_a        (data_in_a),
    .i_b        (data_in_b),
    .o_acc      (c_data)
  );

`ifdef MAC_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_IDLE) && start && !stop) begin
      r_stall_cnt <= '0;
    end else if (r_c_we && !c_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign matrix_a_re = r_re;
  assign matrix_b_re = r_re;
  assign row_addr_a  = r_row_a;
  assign col_addr_a  = r_col_a;
  assign row_addr_b  = r_row_b;
  assign col_addr_b  = r_col_b;
  assign c_we        = r_c_we;
  assign c_row_addr  = r_c_row;
  assign c_col_addr  = r_c_col;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac_seq_ctrl
// Self-checking bench for mac_seq_ctrl. Matrix memories are modelled as
// registered-read arrays; expected C writes come from a plain nested-loop
// matrix product and are queued when a run starts. A negedge monitor pops the
// queue on every accepted C write. Build with MAC_SEQ_STALL_CNT_EN to also
// check stall_cycles.
// -----------------------------------------------------------------------------
module tb_mac_seq_ctrl;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 32;
  localparam int RW = 66;
  localparam int EW = 2 + 2 + RW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn = 1'b0;
  logic          start  = 1'b0;
  logic          stop   = 1'b0;
  logic          c_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [1:0]    row_addr_a;
  logic [1:0]    col_addr_a;
  logic          matrix_a_re;
  logic [1:0]    row_addr_b;
  logic [1:0]    col_addr_b;
  logic          matrix_b_re;
  logic [DW-1:0] data_in_a = '0;
  logic [DW-1:0] data_in_b = '0;
  logic [1:0]    c_row_addr;
  logic [1:0]    c_col_addr;
  logic [RW-1:0] c_data;
  logic          c_we;
`ifdef MAC_SEQ_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  mac_seq_ctrl #(
    .M (M), .N (N), .K (K),
    .DATA_WIDTH_INIT_MATRIX   (DW),
    .DATA_WIDTH_RESULT_MATRIX (RW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .stop        (stop),
    .busy        (busy),
    .done        (done),
    .row_addr_a  (row_addr_a),
    .col_addr_a  (col_addr_a),
    .matrix_a_re (matrix_a_re),
    .row_addr_b  (row_addr_b),
    .col_addr_b  (col_addr_b),
    .matrix_b_re (matrix_b_re),
    .data_in_a   (data_in_a),
    .data_in_b   (data_in_b),
    .c_row_addr  (c_row_addr),
    .c_col_addr  (c_col_addr),
    .c_data      (c_data),
    .c_we        (c_we),
    .c_ready     (c_ready)
`ifdef MAC_SEQ_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // matrix memories: data valid the cycle after the read enable
  logic [DW-1:0] mem_a [M][K];
  logic [DW-1:0] mem_b [K][N];

  always @(posedge clk) begin
    if (matrix_a_re) data_in_a <= mem_a[row_addr_a][col_addr_a];
    if (matrix_b_re) data_in_b <= mem_b[row_addr_b][col_addr_b];
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [RW-1:0] c_got [M][N];
  int            n_checks = 0;
  int            n_errors = 0;
  int            wr_cnt   = 0;
  logic          p_stall  = 1'b0;
  logic [EW-1:0] p_word   = '0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (resetn) begin
      if (c_we) chk("no_read_during_write", {matrix_a_re, matrix_b_re}, 128'd0);
      if (p_stall) chk("stall_hold", {c_we, c_row_addr, c_col_addr, c_data}, {1'b1, p_word});
      if (c_we && c_ready) begin
        wr_cnt++;
        c_got[c_row_addr][c_col_addr] = c_data;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got row=%0d col=%0d data=%0h, expected no write",
                   c_row_addr, c_col_addr, c_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("c_write", {c_row_addr, c_col_addr, c_data}, mon_e);
        end
      end
      p_stall = c_we && !c_ready && !stop;
      p_word  = {c_row_addr, c_col_addr, c_data};
    end
  end

  // reference model: C[i][j] = sum_k A[i][k]*B[k][j], row-major order
  task automatic push_expected(input int n_e);
    int i;
    int j;
    logic [RW-1:0] s;
    for (int e = 0; e < n_e; e++) begin
      i = e / N;
      j = e % N;
      s = '0;
      for (int k = 0; k < K; k++) s = s + RW'(mem_a[i][k]) * RW'(mem_b[k][j]);
      exp_q.push_back({i[1:0], j[1:0], s});
    end
  endtask

  task automatic load_directed();
    int a_v[16] = '{6,2,5,2, 6,2,6,1, 2,4,5,2, 7,2,5,1};
    int b_v[16] = '{1,1,4,4, 1,7,2,1, 3,2,1,1, 2,1,6,6};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mem_a[r][c] = DW'(a_v[r*4+c]);
        mem_b[r][c] = DW'(b_v[r*4+c]);
      end
  endtask

  task automatic load_const(input logic [DW-1:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mem_a[r][c] = v;
        mem_b[r][c] = v;
      end
  endtask

  task automatic load_random();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mem_a[r][c] = ($urandom_range(0, 1) == 1) ? $urandom() : DW'($urandom_range(0, 255));
        mem_b[r][c] = ($urandom_range(0, 1) == 1) ? $urandom() : DW'($urandom_range(0, 255));
      end
  endtask

  task automatic clear_got();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) c_got[r][c] = '0;
  endtask

  // driver: one full run. stall_n = c_ready low for that many cycles on the
  // first write; rnd_ready = random back-pressure; stop_cyc / pulse_cyc = cycle
  // (counted from 1 after the start edge) to pulse stop / a second start.
  task automatic run(input int stall_n, input bit rnd_ready, input int stop_cyc,
                     input int pulse_cyc, output int done_cyc, output int stalls);
    int stall_seen;
    int n_exp;
    int wr0;
    done_cyc   = -1;
    stalls     = 0;
    stall_seen = 0;
    n_exp      = M * N;
    if (stop_cyc > 0) begin
      n_exp = 0;
      for (int e = 0; e < M * N; e++)
        if ((K + 3) * (e + 1) < stop_cyc) n_exp++;
    end
    clear_got();
    push_expected(n_exp);
    wr0     = wr_cnt;
    c_ready = (stall_n > 0) ? 1'b0 : 1'b1;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      start = (cyc == pulse_cyc);
      stop  = (cyc == stop_cyc);
      if (rnd_ready) begin
        c_ready = ($urandom_range(0, 3) != 0);
      end else if (c_we && !c_ready) begin
        if (stall_seen == stall_n) c_ready = 1'b1;
        else stall_seen++;
      end
      if (c_we && !c_ready) stalls++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (stop_cyc > 0 && cyc == stop_cyc + 1) chk("busy_after_stop", busy, 128'd0);
      if (stop_cyc > 0 && cyc == stop_cyc + 200) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    stop  = 1'b0;
    if (stop_cyc > 0) begin
      chk("no_done_after_stop", done_cyc < 0, 128'd1);
    end else begin
      chk("done_cycle", done_cyc, 1 + M * N * (K + 3) + stalls);
      @(posedge clk); #1;
      chk("busy_after_done", {done, busy}, 128'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("write_count", wr_cnt - wr0, n_exp);
    chk("queue_drained", exp_q.size(), 128'd0);
`ifdef MAC_SEQ_STALL_CNT_EN
    if (stop_cyc == 0) chk("stall_cycles", stall_cycles, stalls);
`endif
    c_ready = 1'b1;
  endtask

  task automatic check_directed_values();
    chk("c00_27", c_got[0][0], 128'd27);
    chk("c03_43", c_got[0][3], 128'd43);
    chk("c33_41", c_got[3][3], 128'd41);
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int st;
    logic [RW-1:0] ones_exp;
    ones_exp = 66'h3_FFFF_FFF8_0000_0004;

    // reset held with start high: everything quiet
    resetn = 1'b0;
    start  = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      chk("reset_outputs", {busy, done, matrix_a_re, matrix_b_re, c_we, row_addr_a, col_addr_a,
                            row_addr_b, col_addr_b, c_row_addr, c_col_addr, c_data}, 128'd0);
    end
    resetn  = 1'b1;
    start   = 1'b0;
    c_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", busy, 128'd0);

    // functional run
    load_directed();
    run(0, 1'b0, 0, 0, dc, st);
    chk("done_cycle_113", dc, 128'd113);
    check_directed_values();

    // width corner
    load_const(32'hFFFF_FFFF);
    run(0, 1'b0, 0, 0, dc, st);
    chk("ones_c00", c_got[0][0], ones_exp);
    chk("ones_c33", c_got[3][3], ones_exp);

    // back-pressure on the first write
    load_directed();
    run(5, 1'b0, 0, 0, dc, st);
    chk("stall_count_5", st, 128'd5);
    chk("done_cycle_118", dc, 128'd118);
`ifdef MAC_SEQ_STALL_CNT_EN
    chk("stall_cycles_5", stall_cycles, 128'd5);
`endif

    // abort in cycle 20, then a clean rerun
    run(0, 1'b0, 20, 0, dc, st);
    run(0, 1'b0, 0, 0, dc, st);
    chk("rerun_done_113", dc, 128'd113);
    check_directed_values();

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    for (int r = 0; r < 3; r++) begin
      chk("collision_idle", {busy, matrix_a_re, c_we}, 128'd0);
      @(posedge clk); #1;
    end

    // start pulsed mid-run is ignored
    run(0, 1'b0, 0, 50, dc, st);
    chk("pulse_done_113", dc, 128'd113);

    // randomized data and back-pressure
    for (int t = 0; t < 3; t++) begin
      load_random();
      run(0, 1'b1, 0, 0, dc, st);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
